// File: rtl/xbar_pkg.sv
// Shared crossbar types for the AR issue path.
// Contents:
//   XBAR_*_W          default AXI field widths used by ar_req_t
//   burst_t           AXI burst encoding (FIXED/INCR/WRAP)
//   ar_issue_state_t  AR issue FSM states (IDLE/VALID)
//   ar_req_t          one queued AR request (id, addr, len, size, burst)
package xbar_pkg;

    localparam int XBAR_ID_W   = 4;
    localparam int XBAR_ADDR_W = 32;
    localparam int XBAR_LEN_W  = 4;
    localparam int XBAR_SIZE_W = 3;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } ar_issue_state_t;

    typedef struct packed {
        logic [XBAR_ID_W-1:0]   id;
        logic [XBAR_ADDR_W-1:0] addr;
        logic [XBAR_LEN_W-1:0]  len;
        logic [XBAR_SIZE_W-1:0] size;
        burst_t                 burst;
    } ar_req_t;

endpackage

// File: rtl/ar_issue_ctrl_if.sv
// Master-side AXI AR channel plus the R-channel handshake signals that the
// issue controller monitors to retire bursts.
// Signals:
//   M_ARID/M_ARADDR/M_ARLEN/M_ARSIZE/M_ARBURST  AR payload
//   M_ARVALID/M_ARREADY                         AR handshake
//   M_RVALID/M_RREADY/M_RLAST                   R channel (observed only)
// Modports:
//   master  the issue controller (drives AR, observes R)
//   slave   the downstream side (accepts AR, drives R handshake)
interface ar_issue_ctrl_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
);
    logic [ID_WIDTH-1:0]   M_ARID;
    logic [ADDR_WIDTH-1:0] M_ARADDR;
    logic [LEN_WIDTH-1:0]  M_ARLEN;
    logic [SIZE_WIDTH-1:0] M_ARSIZE;
    logic [1:0]            M_ARBURST;
    logic                  M_ARVALID;
    logic                  M_ARREADY;
    logic                  M_RVALID;
    logic                  M_RREADY;
    logic                  M_RLAST;

    modport master (
        output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
        input  M_ARREADY, M_RVALID, M_RREADY, M_RLAST
    );

    modport slave (
        input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
        output M_ARREADY, M_RVALID, M_RREADY, M_RLAST
    );
endinterface

// File: rtl/ar_watchdog.sv
// ARREADY watchdog: counts consecutive cycles in which an AR is presented but
// not accepted, and raises a sticky flag once the count reaches
// TIMEOUT_CYCLES. The flag only clears on reset; AR flow is never affected.
// Ports:
//   ACLK, ARESETn  clock, synchronous active-low reset
//   stall          AR valid and not ready this cycle
//   handshake      AR accepted this cycle (restarts the count)
//   timeout        sticky timeout flag
module ar_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic stall,
    input  logic handshake,
    output logic timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (handshake) begin
            cnt <= '0;
        end else if (stall) begin
            // Saturate so a very long stall cannot wrap the counter.
            if (cnt != CNT_W'(TIMEOUT_CYCLES))
                cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                timeout <= 1'b1;
        end
    end
endmodule

// File: rtl/ar_issue_ctrl.sv
// AR issue controller: pops queued read requests from the AR pending FIFO,
// presents them on the master AR channel and limits the number of reads in
// flight (AR accepted, RLAST not yet seen) to MAX_OUTSTANDING.
// Optional feature: define AR_TIMEOUT_EN to add the ARREADY watchdog
// (ar_timeout); without it ar_timeout is tied low.
// Ports:
//   ACLK, ARESETn           clock, synchronous active-low reset
//   fifo_empty / fifo_pop   AR FIFO status and pop strobe
//   fifo_AR*                FIFO front entry (valid when !fifo_empty)
//   m_axi                   master AR channel + R monitor (interface)
//   outstanding             reads accepted and not yet closed by RLAST
//   ar_idle                 nothing presented, in flight or queued
//   ar_timeout              sticky ARREADY watchdog flag
module ar_issue_ctrl
    import xbar_pkg::*;
#(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 4,
    parameter int SIZE_WIDTH      = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [ID_WIDTH-1:0]   fifo_ARID,
    input  logic [ADDR_WIDTH-1:0] fifo_ARADDR,
    input  logic [LEN_WIDTH-1:0]  fifo_ARLEN,
    input  logic [SIZE_WIDTH-1:0] fifo_ARSIZE,
    input  logic [1:0]            fifo_ARBURST,
    ar_issue_ctrl_if.master       m_axi,
    output logic [OUT_W-1:0]      outstanding,
    output logic                  ar_idle,
    output logic                  ar_timeout
);
    localparam int CW = OUT_W + 1;

    ar_issue_state_t       state;
    logic [ID_WIDTH-1:0]   arid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [LEN_WIDTH-1:0]  arlen_q;
    logic [SIZE_WIDTH-1:0] arsize_q;
    burst_t                arburst_q;

    logic          ar_hs;
    logic          rlast_beat;
    logic          r_done;
    logic [CW-1:0] committed;
    logic          credit_ok;

    assign ar_hs      = (state == VALID) && m_axi.M_ARREADY;
    assign rlast_beat = m_axi.M_RVALID && m_axi.M_RREADY && m_axi.M_RLAST;
    // A closing beat with nothing in flight is ignored rather than underflowing.
    assign r_done     = rlast_beat && (outstanding != '0);

    // Credit check looks one cycle ahead: this cycle's RLAST already frees a
    // slot, and an AR currently on the bus already holds one (it counts the
    // moment it handshakes, which is exactly when a back-to-back pop happens).
    always_comb begin
        committed = {1'b0, outstanding} - CW'(r_done) + CW'(state == VALID);
        credit_ok = committed < CW'(MAX_OUTSTANDING);
    end

    // Gated by ARESETn so no entry is lost from the FIFO during a reset cycle.
    assign fifo_pop = ARESETn && !fifo_empty && credit_ok &&
                      ((state == IDLE) || ar_hs);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state       <= IDLE;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= FIXED;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + OUT_W'(ar_hs) - OUT_W'(r_done);
            if (fifo_pop) begin
                state     <= VALID;
                arid_q    <= fifo_ARID;
                araddr_q  <= fifo_ARADDR;
                arlen_q   <= fifo_ARLEN;
                arsize_q  <= fifo_ARSIZE;
                arburst_q <= burst_t'(fifo_ARBURST);
            end else if (ar_hs) begin
                state <= IDLE;
            end
        end
    end

    assign m_axi.M_ARVALID = (state == VALID);
    assign m_axi.M_ARID    = arid_q;
    assign m_axi.M_ARADDR  = araddr_q;
    assign m_axi.M_ARLEN   = arlen_q;
    assign m_axi.M_ARSIZE  = arsize_q;
    assign m_axi.M_ARBURST = arburst_q;

    assign ar_idle = (state == IDLE) && (outstanding == '0) && fifo_empty;

`ifdef AR_TIMEOUT_EN
    ar_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .stall    ((state == VALID) && !m_axi.M_ARREADY),
        .handshake(ar_hs),
        .timeout  (ar_timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign ar_timeout = 1'b0;
`endif

    // An RLAST with no read in flight means the R side is out of sync.
    a_no_rlast_underflow: assert property (
        @(posedge ACLK) disable iff (!ARESETn) !(rlast_beat && (outstanding == '0))
    );
endmodule

// File: tb/tb_ar_issue_ctrl.sv
// Self-checking bench for ar_issue_ctrl: reset state, directed sequences for
// single issue, stall, simultaneous AR/RLAST and mid-traffic reset, a
// table-driven back-to-back/credit-limit sequence, then randomized traffic
// against a transaction-level reference model.
module tb_ar_issue_ctrl;
    import xbar_pkg::*;

    localparam int ID_W   = XBAR_ID_W;
    localparam int ADDR_W = XBAR_ADDR_W;
    localparam int LEN_W  = XBAR_LEN_W;
    localparam int SIZE_W = XBAR_SIZE_W;
    localparam int MAXO   = 4;
    localparam int TO     = 8;
    localparam int OUT_W  = $clog2(MAXO + 1);
`ifdef AR_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [ID_W-1:0]   fifo_ARID;
    logic [ADDR_W-1:0] fifo_ARADDR;
    logic [LEN_W-1:0]  fifo_ARLEN;
    logic [SIZE_W-1:0] fifo_ARSIZE;
    logic [1:0]        fifo_ARBURST;
    logic [OUT_W-1:0]  outstanding;
    logic              ar_idle;
    logic              ar_timeout;

    ar_issue_ctrl_if #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .LEN_WIDTH(LEN_W), .SIZE_WIDTH(SIZE_W)
    ) axi ();

    ar_issue_ctrl #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .LEN_WIDTH(LEN_W), .SIZE_WIDTH(SIZE_W),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .fifo_empty  (fifo_empty),
        .fifo_pop    (fifo_pop),
        .fifo_ARID   (fifo_ARID),
        .fifo_ARADDR (fifo_ARADDR),
        .fifo_ARLEN  (fifo_ARLEN),
        .fifo_ARSIZE (fifo_ARSIZE),
        .fifo_ARBURST(fifo_ARBURST),
        .m_axi       (axi.master),
        .outstanding (outstanding),
        .ar_idle     (ar_idle),
        .ar_timeout  (ar_timeout)
    );

    always #5 ACLK = ~ACLK;

    ar_req_t fq[$];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int push;
        bit rdy;
        bit rl;
        bit e_pop;
        bit e_val;
        int e_id;
        int e_out;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        if (fq.size() > 0) begin
            fifo_ARID    = fq[0].id;
            fifo_ARADDR  = fq[0].addr;
            fifo_ARLEN   = fq[0].len;
            fifo_ARSIZE  = fq[0].size;
            fifo_ARBURST = fq[0].burst;
        end else begin
            fifo_ARID    = '0;
            fifo_ARADDR  = '0;
            fifo_ARLEN   = '0;
            fifo_ARSIZE  = '0;
            fifo_ARBURST = '0;
        end
    endtask

    task automatic push(input logic [31:0] id, input logic [31:0] addr, input logic [31:0] len,
                        input logic [31:0] size, input logic [31:0] burst);
        ar_req_t r;
        r.id    = id[ID_W-1:0];
        r.addr  = addr;
        r.len   = len[LEN_W-1:0];
        r.size  = size[SIZE_W-1:0];
        r.burst = burst_t'(burst[1:0]);
        fq.push_back(r);
        drive_fifo();
    endtask

    task automatic set_in(input bit rdy, input bit rv, input bit rr, input bit rl);
        axi.M_ARREADY = rdy;
        axi.M_RVALID  = rv;
        axi.M_RREADY  = rr;
        axi.M_RLAST   = rl;
    endtask

    // Called at the falling edge: commits the sampled pop at the next rising
    // edge and returns just after it, ready for new inputs.
    task automatic tick();
        bit p;
        p = fifo_pop;
        @(posedge ACLK);
        #1;
        if (p && fq.size() > 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        fq.delete();
        drive_fifo();
        set_in(0, 0, 0, 0);
        repeat (2) begin
            @(negedge ACLK);
            tick();
        end
        ARESETn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        ar_req_t bus[$];
        int  m_out;
        int  stall;
        bit  m_to;
        bit  m_valid, hs, done, room, e_pop, rdy, rv, rr, rl;

        drive_fifo();
        set_in(0, 0, 0, 0);

        // Reset state
        do_reset();
        @(negedge ACLK);
        chk("rst_arvalid", axi.M_ARVALID, 0);
        chk("rst_arid", axi.M_ARID, 0);
        chk("rst_araddr", axi.M_ARADDR, 0);
        chk("rst_arburst", axi.M_ARBURST, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_idle", ar_idle, 1);
        chk("rst_timeout", ar_timeout, 0);
        tick();

        // Single AR: valid one cycle after the FIFO goes non-empty
        push(3, 32'h1000, 7, 2, 1);
        set_in(1, 0, 0, 0);
        @(negedge ACLK);
        chk("t1_pop", fifo_pop, 1);
        chk("t1_valid_early", axi.M_ARVALID, 0);
        tick();
        @(negedge ACLK);
        chk("t1_valid", axi.M_ARVALID, 1);
        chk("t1_id", axi.M_ARID, 3);
        chk("t1_addr", axi.M_ARADDR, 32'h1000);
        chk("t1_len", axi.M_ARLEN, 7);
        chk("t1_size", axi.M_ARSIZE, 2);
        chk("t1_burst", axi.M_ARBURST, 1);
        chk("t1_no_second_pop", fifo_pop, 0);
        tick();
        @(negedge ACLK);
        chk("t1_valid_drop", axi.M_ARVALID, 0);
        chk("t1_outstanding", outstanding, 1);
        chk("t1_not_idle", ar_idle, 0);
        tick();
        set_in(1, 1, 1, 1);
        @(negedge ACLK);
        chk("t1_out_before_rlast", outstanding, 1);
        tick();
        set_in(1, 0, 0, 0);
        @(negedge ACLK);
        chk("t1_out_after_rlast", outstanding, 0);
        chk("t1_idle", ar_idle, 1);
        tick();

        // ARREADY stall for 10 cycles, handshake in cycle 11
        push(5, 32'h3000, 3, 3, 2);
        push(6, 32'h3040, 1, 2, 1);
        set_in(0, 0, 0, 0);
        @(negedge ACLK);
        chk("t3_pop", fifo_pop, 1);
        tick();
        for (int k = 1; k <= 10; k++) begin
            @(negedge ACLK);
            chk("t3_valid_held", axi.M_ARVALID, 1);
            chk("t3_id_stable", axi.M_ARID, 5);
            chk("t3_addr_stable", axi.M_ARADDR, 32'h3000);
            chk("t3_no_pop", fifo_pop, 0);
            chk("t3_timeout", ar_timeout, WD_ON && (k >= TO + 1));
            tick();
        end
        set_in(1, 0, 0, 0);
        @(negedge ACLK);
        chk("t3_hs_valid", axi.M_ARVALID, 1);
        chk("t3_hs_id", axi.M_ARID, 5);
        chk("t3_b2b_pop", fifo_pop, 1);
        tick();
        @(negedge ACLK);
        chk("t3_next_id", axi.M_ARID, 6);
        chk("t3_next_len", axi.M_ARLEN, 1);
        chk("t3_out1", outstanding, 1);
        tick();
        @(negedge ACLK);
        chk("t3_out2", outstanding, 2);
        chk("t3_timeout_sticky", ar_timeout, WD_ON);
        tick();

        // AR handshake and RLAST in the same cycle at outstanding=2
        push(7, 32'h4000, 0, 0, 0);
        @(negedge ACLK);
        chk("t4_pop", fifo_pop, 1);
        tick();
        set_in(1, 1, 1, 1);
        @(negedge ACLK);
        chk("t4_valid", axi.M_ARVALID, 1);
        chk("t4_out_before", outstanding, 2);
        tick();
        set_in(1, 0, 0, 0);
        @(negedge ACLK);
        chk("t4_out_unchanged", outstanding, 2);
        tick();

        // Reset with ARVALID=1 and outstanding=3
        push(9, 32'h5000, 2, 2, 1);
        push(10, 32'h5100, 2, 2, 1);
        @(negedge ACLK);
        tick();
        @(negedge ACLK);
        chk("t5_b2b_pop", fifo_pop, 1);
        tick();
        set_in(0, 0, 0, 0);
        push(11, 32'h5200, 2, 2, 1);
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("t5_pre_valid", axi.M_ARVALID, 1);
        chk("t5_pre_out", outstanding, 3);
        chk("t5_pop_in_reset", fifo_pop, 0);
        tick();
        @(negedge ACLK);
        chk("t5_valid_cleared", axi.M_ARVALID, 0);
        chk("t5_out_cleared", outstanding, 0);
        chk("t5_no_pop", fifo_pop, 0);
        tick();
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("t5_pop_after_release", fifo_pop, 1);
        tick();
        @(negedge ACLK);
        chk("t5_id_after_release", axi.M_ARID, 11);
        tick();

        // Back-to-back issue up to the credit limit, then release by RLAST
        tbl[0] = '{5, 1, 0, 1, 0, -1, 0};
        tbl[1] = '{0, 1, 0, 1, 1,  8, 0};
        tbl[2] = '{0, 1, 0, 1, 1,  9, 1};
        tbl[3] = '{0, 1, 0, 1, 1, 10, 2};
        tbl[4] = '{0, 1, 0, 0, 1, 11, 3};
        tbl[5] = '{0, 1, 0, 0, 0, -1, 4};
        tbl[6] = '{0, 1, 0, 0, 0, -1, 4};
        tbl[7] = '{0, 1, 1, 1, 0, -1, 4};
        tbl[8] = '{0, 1, 0, 0, 1, 12, 3};
        tbl[9] = '{0, 1, 0, 0, 0, -1, 4};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int n = 0; n < tbl[i].push; n++)
                push(8 + n, 32'h2000 + n * 64, n, 2, 1);
            set_in(tbl[i].rdy, tbl[i].rl, tbl[i].rl, tbl[i].rl);
            @(negedge ACLK);
            chk($sformatf("tbl%0d_pop", i), fifo_pop, tbl[i].e_pop);
            chk($sformatf("tbl%0d_valid", i), axi.M_ARVALID, tbl[i].e_val);
            chk($sformatf("tbl%0d_out", i), outstanding, tbl[i].e_out);
            if (tbl[i].e_id >= 0) begin
                chk($sformatf("tbl%0d_id", i), axi.M_ARID, tbl[i].e_id);
                chk($sformatf("tbl%0d_addr", i), axi.M_ARADDR, 32'h2000 + (tbl[i].e_id - 8) * 64);
            end
            tick();
        end
        set_in(0, 1, 1, 1);
        for (int d = 0; d < 4; d++) begin
            @(negedge ACLK);
            chk("drain_out", outstanding, MAXO - d);
            tick();
        end
        set_in(0, 0, 0, 0);
        @(negedge ACLK);
        chk("drain_empty", outstanding, 0);
        chk("drain_idle", ar_idle, 1);
        tick();

        // Randomized traffic against a transaction-level model: 'bus' holds the
        // AR currently presented, m_out the reads in flight.
        do_reset();
        m_out = 0;
        stall = 0;
        m_to  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (fq.size() < 6 && $urandom_range(0, 2) == 0)
                push($urandom_range(0, 15), $urandom, $urandom_range(0, 15),
                     $urandom_range(0, 7), $urandom_range(0, 2));
            rdy = ($urandom_range(0, 3) != 0);
            rv  = $urandom_range(0, 1);
            rr  = $urandom_range(0, 1);
            rl  = (m_out > 0) ? bit'($urandom_range(0, 1)) : 1'b0;
            set_in(rdy, rv, rr, rl);
            @(negedge ACLK);
            m_valid = (bus.size() > 0);
            hs      = m_valid && rdy;
            done    = rv && rr && rl;
            room    = (m_out - int'(done) + int'(m_valid)) < MAXO;
            e_pop   = (fq.size() > 0) && room && (!m_valid || hs);
            chk("rnd_pop", fifo_pop, e_pop);
            chk("rnd_valid", axi.M_ARVALID, m_valid);
            chk("rnd_out", outstanding, m_out);
            chk("rnd_idle", ar_idle, !m_valid && (m_out == 0) && (fq.size() == 0));
            chk("rnd_timeout", ar_timeout, m_to);
            if (m_valid) begin
                chk("rnd_id", axi.M_ARID, bus[0].id);
                chk("rnd_addr", axi.M_ARADDR, bus[0].addr);
                chk("rnd_len", axi.M_ARLEN, bus[0].len);
                chk("rnd_size", axi.M_ARSIZE, bus[0].size);
                chk("rnd_burst", axi.M_ARBURST, bus[0].burst);
            end
            if (hs) void'(bus.pop_front());
            if (e_pop) bus.push_back(fq[0]);
            m_out = m_out + int'(hs) - int'(done);
            if (m_valid && !rdy) begin
                stall++;
                if (stall == TO) m_to = WD_ON;
            end else if (hs) begin
                stall = 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
